// File: rtl/pong_pkg.sv
// Shared Pong constants, FSM state encoding and ball state payload.
package pong_pkg;

  localparam int unsigned H_ACTIVE     = 640;
  localparam int unsigned V_ACTIVE     = 480;
  localparam int unsigned BALL_HALF    = 4;
  localparam int unsigned SPEED        = 2;
  localparam int unsigned SERVE_FRAMES = 60;
  localparam int unsigned SCORE_MAX    = 9;

  localparam int unsigned POS_W   = 10;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned SERVE_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_SCORED = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  typedef enum logic {
    DX_RIGHT = 1'b0,
    DX_LEFT  = 1'b1
  } dx_t;

  typedef enum logic {
    DY_DOWN = 1'b0,
    DY_UP   = 1'b1
  } dy_t;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    dx_t              dx;
    dy_t              dy;
  } ball_t;

endpackage

// File: rtl/score_counter.sv
// Per-player saturating score register with synchronous clear.
module score_counter
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               clr,
  output logic [SCORE_W-1:0] score,
  output logic               at_max_c
);

  assign at_max_c = (score == SCORE_W'(SCORE_MAX));

  // Clear wins over increment; increment stops at the winning score.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score <= '0;
    end else if (clr) begin
      score <= '0;
    end else if (inc && !at_max_c) begin
      score <= score + SCORE_W'(1);
    end
  end

endmodule

// File: rtl/ball_engine.sv
// Pong ball: motion, wall/paddle collisions, serve timing, scoring and game over.
module ball_engine
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [POS_W-1:0]   hsp,
  input  logic [POS_W-1:0]   vsp,
  input  logic               paddle_l_hit,
  input  logic               paddle_r_hit,
  input  logic               start,
  output logic               ball_on,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               point_l,
  output logic               point_r,
  output logic               game_over
);

  localparam logic [POS_W-1:0]   X_CTR      = POS_W'(H_ACTIVE / 2);
  localparam logic [POS_W-1:0]   Y_CTR      = POS_W'(V_ACTIVE / 2);
  localparam logic [POS_W-1:0]   HALF       = POS_W'(BALL_HALF);
  localparam logic [POS_W-1:0]   STEP       = POS_W'(SPEED);
  localparam logic [POS_W-1:0]   EDGE_LO    = POS_W'(BALL_HALF + SPEED);
  localparam logic [POS_W-1:0]   X_MAX      = POS_W'(H_ACTIVE - 1);
  localparam logic [POS_W-1:0]   Y_MAX      = POS_W'(V_ACTIVE - 1);
  localparam logic [POS_W-1:0]   TICK_LINE  = POS_W'(V_ACTIVE);
  localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_FRAMES - 1);

  state_t             state, state_next;
  ball_t              ball, ball_next;
  dx_t                dx_eff_c;
  logic [SERVE_W-1:0] serve_cnt, serve_cnt_next;
  logic               hit_l, hit_r;
  logic               frame_tick_c;
  logic               inc_l_c, inc_r_c, clr_c;
  logic               max_l_c, max_r_c;

  // Start of the first blanking line paces all motion.
  assign frame_tick_c = (hsp == '0) && (vsp == TICK_LINE);

  // Ball pixel strobe, one cycle behind hsp/vsp to line up with paddle hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ball_on <= 1'b0;
    end else begin
      ball_on <= (hsp >= ball.x - HALF) && (hsp < ball.x + HALF) &&
                 (vsp >= ball.y - HALF) && (vsp < ball.y + HALF);
    end
  end

  // Sticky paddle contact flags, consumed and cleared on the frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_l <= 1'b0;
      hit_r <= 1'b0;
    end else if (frame_tick_c) begin
      hit_l <= 1'b0;
      hit_r <= 1'b0;
    end else begin
      if (ball_on && paddle_l_hit) hit_l <= 1'b1;
      if (ball_on && paddle_r_hit) hit_r <= 1'b1;
    end
  end

  // State, ball and serve-timer registers plus registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ball      <= '{x: X_CTR, y: Y_CTR, dx: DX_RIGHT, dy: DY_DOWN};
      serve_cnt <= '0;
      point_l   <= 1'b0;
      point_r   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_next;
      ball      <= ball_next;
      serve_cnt <= serve_cnt_next;
      point_l   <= inc_l_c;
      point_r   <= inc_r_c;
      game_over <= (state_next == ST_OVER);
    end
  end

  // Next-state: start detection is immediate, everything else waits for the frame tick.
  always_comb begin
    state_next     = state;
    ball_next      = ball;
    serve_cnt_next = serve_cnt;
    dx_eff_c       = ball.dx;
    inc_l_c        = 1'b0;
    inc_r_c        = 1'b0;
    clr_c          = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next     = ST_SERVE;
          serve_cnt_next = '0;
        end
      end

      ST_SERVE: begin
        if (frame_tick_c) begin
          if (serve_cnt == SERVE_LAST) state_next = ST_PLAY;
          else                         serve_cnt_next = serve_cnt + SERVE_W'(1);
        end
      end

      ST_PLAY: begin
        if (frame_tick_c) begin
          if (hit_l && (ball.dx == DX_LEFT))       dx_eff_c = DX_RIGHT;
          else if (hit_r && (ball.dx == DX_RIGHT)) dx_eff_c = DX_LEFT;
          ball_next.dx = dx_eff_c;

          // Vertical: bounce in place at the top/bottom edge, else step.
          if (ball.dy == DY_UP) begin
            if (ball.y < EDGE_LO) ball_next.dy = DY_DOWN;
            else                  ball_next.y  = ball.y - STEP;
          end else begin
            if (ball.y + EDGE_LO > Y_MAX) ball_next.dy = DY_UP;
            else                          ball_next.y  = ball.y + STEP;
          end

          // Horizontal: a miss scores and re-serves toward the conceding side.
          if ((dx_eff_c == DX_LEFT) && (ball.x < EDGE_LO)) begin
            inc_r_c    = 1'b1;
            ball_next  = '{x: X_CTR, y: Y_CTR, dx: DX_LEFT, dy: DY_DOWN};
            state_next = ST_SCORED;
          end else if ((dx_eff_c == DX_RIGHT) && (ball.x + EDGE_LO > X_MAX)) begin
            inc_l_c    = 1'b1;
            ball_next  = '{x: X_CTR, y: Y_CTR, dx: DX_RIGHT, dy: DY_DOWN};
            state_next = ST_SCORED;
          end else if (dx_eff_c == DX_LEFT) begin
            ball_next.x = ball.x - STEP;
          end else begin
            ball_next.x = ball.x + STEP;
          end
        end
      end

      ST_SCORED: begin
        if (frame_tick_c) begin
          serve_cnt_next = '0;
          if (max_l_c || max_r_c) state_next = ST_OVER;
          else                    state_next = ST_SERVE;
        end
      end

      ST_OVER: begin
        if (start) begin
          clr_c          = 1'b1;
          ball_next.dx   = DX_RIGHT;
          serve_cnt_next = '0;
          state_next     = ST_SERVE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  score_counter u_score_l (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (inc_l_c),
    .clr      (clr_c),
    .score    (score_l),
    .at_max_c (max_l_c)
  );

  score_counter u_score_r (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (inc_r_c),
    .clr      (clr_c),
    .score    (score_r),
    .at_max_c (max_r_c)
  );

endmodule

// File: tb/tb_ball_engine.sv
// Randomized self-checking bench for ball_engine with a frame-level game model.
module tb_ball_engine;

  localparam int H_ACT   = 640;
  localparam int V_ACT   = 480;
  localparam int HALF    = 4;
  localparam int SPD     = 2;
  localparam int SERVE_N = 60;
  localparam int SMAX    = 9;

  localparam int M_IDLE   = 0;
  localparam int M_SERVE  = 1;
  localparam int M_PLAY   = 2;
  localparam int M_SCORED = 3;
  localparam int M_OVER   = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hsp, vsp;
  logic       paddle_l_hit, paddle_r_hit, start;
  logic       ball_on, point_l, point_r, game_over;
  logic [3:0] score_l, score_r;

  int n_checks = 0;
  int n_errors = 0;

  // Game model: position, direction (+1 right/down, -1 left/up), mode, scores.
  int m_mode, m_x, m_y, m_dx, m_dy, m_serve, m_sl, m_sr;
  bit m_hit_l, m_hit_r, exp_on, exp_pl, exp_pr;

  always #5 clk = ~clk;

  ball_engine dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hsp          (hsp),
    .vsp          (vsp),
    .paddle_l_hit (paddle_l_hit),
    .paddle_r_hit (paddle_r_hit),
    .start        (start),
    .ball_on      (ball_on),
    .score_l      (score_l),
    .score_r      (score_r),
    .point_l      (point_l),
    .point_r      (point_r),
    .game_over    (game_over)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_x = H_ACT / 2; m_y = V_ACT / 2; m_dx = 1; m_dy = 1;
    m_serve = 0; m_sl = 0; m_sr = 0; m_hit_l = 0; m_hit_r = 0;
    exp_on = 0; exp_pl = 0; exp_pr = 0;
  endtask

  function automatic bit in_ball(input int h, input int v);
    return (h >= m_x - HALF) && (h < m_x + HALF) && (v >= m_y - HALF) && (v < m_y + HALF);
  endfunction

  function automatic int clip(input int a, input int hi);
    return (a < 0) ? 0 : ((a > hi) ? hi : a);
  endfunction

  // One frame of game rules: the ball would leave the screen -> bounce or score.
  task automatic frame_step();
    int dir, nx, ny;
    case (m_mode)
      M_SERVE: begin
        m_serve++;
        if (m_serve == SERVE_N) m_mode = M_PLAY;
      end
      M_PLAY: begin
        dir = m_dx;
        if (m_hit_l && dir < 0)      dir = 1;
        else if (m_hit_r && dir > 0) dir = -1;
        nx = m_x + SPD * dir;
        ny = m_y + SPD * m_dy;
        if (ny - HALF < 0 || ny + HALF > V_ACT - 1) m_dy = -m_dy;
        else                                        m_y = ny;
        if (nx - HALF < 0) begin
          if (m_sr < SMAX) m_sr++;
          exp_pr = 1; m_x = H_ACT / 2; m_y = V_ACT / 2; m_dx = -1; m_dy = 1; m_mode = M_SCORED;
        end else if (nx + HALF > H_ACT - 1) begin
          if (m_sl < SMAX) m_sl++;
          exp_pl = 1; m_x = H_ACT / 2; m_y = V_ACT / 2; m_dx = 1; m_dy = 1; m_mode = M_SCORED;
        end else begin
          m_x = nx; m_dx = dir;
        end
      end
      M_SCORED: begin
        m_mode  = (m_sl == SMAX || m_sr == SMAX) ? M_OVER : M_SERVE;
        m_serve = 0;
      end
      default: ;
    endcase
  endtask

  // Present one pixel (paddle inputs refer to the previous pixel) and check all outputs.
  task automatic run_cycle(input int h, input int v, input bit pl, input bit pr);
    bit tick, on_now;
    hsp = 10'(h); vsp = 10'(v); paddle_l_hit = pl; paddle_r_hit = pr;
    tick   = (h == 0) && (v == V_ACT);
    on_now = in_ball(h, v);
    exp_pl = 0; exp_pr = 0;
    if ((m_mode == M_IDLE || m_mode == M_OVER) && start) begin
      if (m_mode == M_OVER) begin m_sl = 0; m_sr = 0; m_dx = 1; end
      m_mode = M_SERVE; m_serve = 0;
    end else if (tick) begin
      frame_step();
    end
    if (tick) begin
      m_hit_l = 0; m_hit_r = 0;
    end else begin
      if (exp_on && pl) m_hit_l = 1;
      if (exp_on && pr) m_hit_r = 1;
    end
    exp_on = on_now;
    @(posedge clk); #1;
    check_eq("ball_on", ball_on, exp_on);
    check_eq("point_l", point_l, exp_pl);
    check_eq("point_r", point_r, exp_pr);
    check_eq("score_l", score_l, m_sl);
    check_eq("score_r", score_r, m_sr);
    check_eq("game_over", game_over, (m_mode == M_OVER) ? 1 : 0);
  endtask

  // Sparse frame: pixels near the ball, a few anywhere, the ball edges, then the tick.
  task automatic run_frame(input bit pnoise, input bit snoise);
    int h, v;
    start = snoise && (m_mode == M_SERVE || m_mode == M_PLAY) && ($urandom_range(0, 1) == 1);
    for (int i = 0; i < 6; i++) begin
      h = clip(m_x - 6 + int'($urandom_range(0, 11)), 1023);
      v = clip(m_y - 6 + int'($urandom_range(0, 11)), V_ACT - 1);
      run_cycle(h, v, pnoise && ($urandom_range(0, 2) == 0), pnoise && ($urandom_range(0, 2) == 0));
    end
    for (int i = 0; i < 2; i++)
      run_cycle(int'($urandom_range(0, H_ACT - 1)), int'($urandom_range(0, V_ACT - 1)), 1'b0, 1'b0);
    run_cycle(m_x - HALF, m_y - HALF, 1'b0, 1'b0);
    run_cycle(m_x + HALF - 1, m_y + HALF - 1, 1'b0, 1'b0);
    run_cycle(m_x + HALF, m_y, 1'b0, 1'b0);
    run_cycle(clip(m_x - HALF - 1, 1023), m_y, 1'b0, 1'b0);
    run_cycle(0, V_ACT, 1'b0, 1'b0);
    run_cycle(1, V_ACT, 1'b0, 1'b0);
    start = 1'b0;
  endtask

  task automatic run_until(input int target, input int max_frames, input bit pnoise,
                           input bit snoise, input string tag);
    int n;
    n = 0;
    while (m_mode != target && n < max_frames) begin
      run_frame(pnoise, snoise);
      n++;
    end
    check_eq(tag, m_mode, target);
  endtask

  // Scan across the centred ball and compare against the fixed 316..323 x 236..243 window.
  task automatic centre_scan();
    for (int h = 314; h <= 325; h++) begin
      run_cycle(h, 240, 1'b0, 1'b0);
      check_eq("win_h", ball_on, (h >= 316 && h <= 323) ? 1 : 0);
    end
    for (int v = 234; v <= 245; v++) begin
      run_cycle(320, v, 1'b0, 1'b0);
      check_eq("win_v", ball_on, (v >= 236 && v <= 243) ? 1 : 0);
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_ball_on", ball_on, 0);
    check_eq("rst_score_l", score_l, 0);
    check_eq("rst_score_r", score_r, 0);
    check_eq("rst_point_l", point_l, 0);
    check_eq("rst_point_r", point_r, 0);
    check_eq("rst_game_over", game_over, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; paddle_l_hit = 1'b0; paddle_r_hit = 1'b0;
    hsp = '0; vsp = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    centre_scan();

    // Serve, then first PLAY frame moves the ball to 322,242.
    start = 1'b1; run_cycle(5, 5, 1'b0, 1'b0); start = 1'b0;
    run_until(M_PLAY, 80, 1'b0, 1'b1, "reach_play");
    run_frame(1'b0, 1'b0);
    run_cycle(318, 238, 1'b0, 1'b0); check_eq("play1_lo_in", ball_on, 1);
    run_cycle(317, 238, 1'b0, 1'b0); check_eq("play1_lo_out", ball_on, 0);
    run_cycle(325, 245, 1'b0, 1'b0); check_eq("play1_hi_in", ball_on, 1);
    run_cycle(326, 242, 1'b0, 1'b0); check_eq("play1_hi_out", ball_on, 0);

    // Rally to the right wall: left scores.
    run_until(M_SCORED, 300, 1'b0, 1'b1, "first_point");

    // Right paddle deflect at x=620.
    begin
      int n;
      n = 0;
      while (!(m_mode == M_PLAY && m_x == 620 && m_dx > 0) && n < 400) begin
        run_frame(1'b0, 1'b0);
        n++;
      end
      check_eq("deflect_reach", m_x, 620);
      run_cycle(m_x, m_y, 1'b0, 1'b0);
      run_cycle(700, 500, 1'b0, 1'b1);
      run_cycle(0, V_ACT, 1'b0, 1'b0);
      run_cycle(614, m_y, 1'b0, 1'b0); check_eq("deflect_lo_in", ball_on, 1);
      run_cycle(622, m_y, 1'b0, 1'b0); check_eq("deflect_hi_out", ball_on, 0);
      check_eq("deflect_no_point", score_l, 1);
    end
    run_until(M_SCORED, 400, 1'b0, 1'b0, "right_point");

    // Random paddle contacts for a while.
    for (int i = 0; i < 60; i++) run_frame(1'b1, 1'b1);

    // Asynchronous reset in the middle of play.
    run_until(M_PLAY, 200, 1'b0, 1'b0, "reach_play2");
    for (int i = 0; i < 5; i++) run_frame(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    centre_scan();

    // Left scores nine times in a row; game ends.
    start = 1'b1; run_cycle(5, 5, 1'b0, 1'b0); start = 1'b0;
    run_until(M_OVER, 2600, 1'b0, 1'b1, "reach_over");
    check_eq("over_score_l", score_l, SMAX);
    check_eq("over_score_r", score_r, 0);
    for (int i = 0; i < 4; i++) run_frame(1'b0, 1'b0);
    check_eq("over_held", game_over, 1);

    // Restart from OVER.
    start = 1'b1; run_cycle(5, 5, 1'b0, 1'b0); start = 1'b0;
    check_eq("restart_score_l", score_l, 0);
    check_eq("restart_game_over", game_over, 0);
    for (int i = 0; i < 3; i++) run_frame(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
